// File: rtl/ram256_arbiter.sv
// Two-port arbiter in front of a single RAM256 macro: grants one requester,
// sequences the RAM access over ACCESS/CAPTURE and returns a one-cycle ack.
module ram256_arbiter #(
    parameter int WSIZE = 1,
    parameter bit FAIR  = 1'b1
) (
    input  logic                 CLK,
    input  logic                 RESETn,
    input  logic                 p0_req,
    input  logic [WSIZE-1:0]     p0_we,
    input  logic [7:0]           p0_addr,
    input  logic [8*WSIZE-1:0]   p0_wdata,
    output logic                 p0_ack,
    output logic [8*WSIZE-1:0]   p0_rdata,
    input  logic                 p1_req,
    input  logic [WSIZE-1:0]     p1_we,
    input  logic [7:0]           p1_addr,
    input  logic [8*WSIZE-1:0]   p1_wdata,
    output logic                 p1_ack,
    output logic [8*WSIZE-1:0]   p1_rdata,
    output logic                 ram_en,
    output logic [WSIZE-1:0]     ram_we,
    output logic [7:0]           ram_a,
    output logic [8*WSIZE-1:0]   ram_di,
    input  logic [8*WSIZE-1:0]   ram_do,
    output logic                 busy,
    output logic                 gnt
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACCESS  = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_ACK     = 2'd3
    } state_t;

    state_t               state_r;
    state_t               state_s;
    logic                 last_r;
    logic                 last_s;
    logic [WSIZE-1:0]     cmd_we_r;
    logic [WSIZE-1:0]     cmd_we_s;
    logic                 win_s;
    logic                 gnt_s;
    logic                 busy_s;
    logic                 ram_en_s;
    logic [WSIZE-1:0]     ram_we_s;
    logic [7:0]           ram_a_s;
    logic [8*WSIZE-1:0]   ram_di_s;
    logic                 p0_ack_s;
    logic                 p1_ack_s;
    logic [8*WSIZE-1:0]   p0_rdata_s;
    logic [8*WSIZE-1:0]   p1_rdata_s;

    // Winner selection: with both requesting, round-robin avoids the last owner.
    always_comb begin
        win_s = 1'b0;
        if (p0_req && p1_req) begin
            if (FAIR) begin
                win_s = ~last_r;
            end else begin
                win_s = 1'b0;
            end
        end else if (p1_req) begin
            win_s = 1'b1;
        end else begin
            win_s = 1'b0;
        end
    end

    // Next-state and next-output logic; every output is registered below.
    always_comb begin
        state_s    = state_r;
        last_s     = last_r;
        cmd_we_s   = cmd_we_r;
        gnt_s      = gnt;
        busy_s     = busy;
        ram_en_s   = 1'b0;
        ram_we_s   = {WSIZE{1'b0}};
        ram_a_s    = ram_a;
        ram_di_s   = ram_di;
        p0_ack_s   = 1'b0;
        p1_ack_s   = 1'b0;
        p0_rdata_s = p0_rdata;
        p1_rdata_s = p1_rdata;
        case (state_r)
            ST_IDLE: begin
                if (p0_req || p1_req) begin
                    state_s  = ST_ACCESS;
                    busy_s   = 1'b1;
                    gnt_s    = win_s;
                    last_s   = win_s;
                    ram_en_s = 1'b1;
                    if (win_s) begin
                        ram_we_s = p1_we;
                        cmd_we_s = p1_we;
                        ram_a_s  = p1_addr;
                        ram_di_s = p1_wdata;
                    end else begin
                        ram_we_s = p0_we;
                        cmd_we_s = p0_we;
                        ram_a_s  = p0_addr;
                        ram_di_s = p0_wdata;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_ACCESS: begin
                state_s = ST_CAPTURE;
            end
            ST_CAPTURE: begin
                state_s  = ST_ACK;
                p0_ack_s = ~gnt;
                p1_ack_s = gnt;
                // Read data is only valid one cycle after the RAM access edge.
                if (cmd_we_r == {WSIZE{1'b0}}) begin
                    if (gnt) begin
                        p1_rdata_s = ram_do;
                    end else begin
                        p0_rdata_s = ram_do;
                    end
                end else begin
                    p0_rdata_s = p0_rdata;
                end
            end
            ST_ACK: begin
                state_s = ST_IDLE;
                busy_s  = 1'b0;
            end
            default: begin
                state_s = ST_IDLE;
                busy_s  = 1'b0;
            end
        endcase
    end

    // State and output registers; reset clears everything except last (=1).
    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            state_r  <= ST_IDLE;
            last_r   <= 1'b1;
            cmd_we_r <= {WSIZE{1'b0}};
            gnt      <= 1'b0;
            busy     <= 1'b0;
            ram_en   <= 1'b0;
            ram_we   <= {WSIZE{1'b0}};
            ram_a    <= 8'h00;
            ram_di   <= {(8*WSIZE){1'b0}};
            p0_ack   <= 1'b0;
            p1_ack   <= 1'b0;
            p0_rdata <= {(8*WSIZE){1'b0}};
            p1_rdata <= {(8*WSIZE){1'b0}};
        end else begin
            state_r  <= state_s;
            last_r   <= last_s;
            cmd_we_r <= cmd_we_s;
            gnt      <= gnt_s;
            busy     <= busy_s;
            ram_en   <= ram_en_s;
            ram_we   <= ram_we_s;
            ram_a    <= ram_a_s;
            ram_di   <= ram_di_s;
            p0_ack   <= p0_ack_s;
            p1_ack   <= p1_ack_s;
            p0_rdata <= p0_rdata_s;
            p1_rdata <= p1_rdata_s;
        end
    end

endmodule
